mat_mult_seq: RTL and testbench

Parametrised NxN matrix multiplier, C = A x B, using one shared multiply-accumulate unit. A and B elements stream in through a valid/ready handshake in row-major order. C elements stream out row-major through a valid/ready handshake. It replaces the fixed 2x2 parallel multiplier array where area matters more than throughput.

---
 rtl/mat_mult_seq.sv | 136 +++++++++++++
 tb/tb_mat_mult_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mat_mult_seq.sv
// NxN matrix multiplier C = A x B built around one shared multiply-accumulate unit.
// Define MAT_MULT_SIGNED_EN to treat A/B elements as two's-complement signed values.
module mat_mult_seq #(
    parameter  int WIDTH = 8,
    parameter  int N     = 2,
    localparam int ACC_W = 2*WIDTH + $clog2(N)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_last,
    output logic             busy
);
    localparam int IW = $clog2(N);
    localparam int EW = $clog2(N*N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N-1);
    localparam logic [EW-1:0] LAST_E   = EW'(N*N-1);

    typedef enum logic [1:0] {LOAD, COMPUTE, OUT} state_t;
    state_t state, next_state;

    logic [EW-1:0]    e;
    logic [IW-1:0]    i, j, k;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] mat_a [N*N];
    logic [WIDTH-1:0] mat_b [N*N];

    logic [EW-1:0]      a_idx, b_idx;
    logic [WIDTH-1:0]   a_el, b_el;
    logic [2*WIDTH-1:0] op_a, op_b, prod_raw;
    logic [ACC_W-1:0]   prod, sum;
    logic               prod_ext;
    logic               last_elem;

    assign a_idx = EW'(i) * EW'(N) + EW'(k);
    assign b_idx = EW'(k) * EW'(N) + EW'(j);
    assign a_el  = mat_a[a_idx];
    assign b_el  = mat_b[b_idx];

    // Operands widened to 2*WIDTH so the truncated product is exact in either signedness.
`ifdef MAT_MULT_SIGNED_EN
    assign op_a     = {{WIDTH{a_el[WIDTH-1]}}, a_el};
    assign op_b     = {{WIDTH{b_el[WIDTH-1]}}, b_el};
    assign prod_raw = op_a * op_b;
    assign prod_ext = prod_raw[2*WIDTH-1];
`else
    assign op_a     = {{WIDTH{1'b0}}, a_el};
    assign op_b     = {{WIDTH{1'b0}}, b_el};
    assign prod_raw = op_a * op_b;
    assign prod_ext = 1'b0;
`endif
    assign prod = {{(ACC_W-2*WIDTH){prod_ext}}, prod_raw};
    assign sum  = acc + prod;

    assign last_elem = (i == LAST_IDX) && (j == LAST_IDX);
    assign in_ready  = (state == LOAD);
    assign out_valid = (state == OUT);
    assign out_last  = (state == OUT) && last_elem;
    assign busy      = !((state == LOAD) && (e == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= LOAD;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (in_valid && e == LAST_E) next_state = COMPUTE;
            COMPUTE: if (k == LAST_IDX)           next_state = OUT;
            OUT:     if (out_ready)               next_state = last_elem ? LOAD : COMPUTE;
            default:                              next_state = LOAD;
        endcase
    end

    // Matrix storage carries no reset; it is always fully rewritten before use.
    always_ff @(posedge clk) begin
        if (state == LOAD && in_valid) begin
            mat_a[e] <= in_a;
            mat_b[e] <= in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e        <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            case (state)
                LOAD: if (in_valid) begin
                    if (e == LAST_E) begin
                        e   <= '0;
                        i   <= '0;
                        j   <= '0;
                        k   <= '0;
                        acc <= '0;
                    end else begin
                        e <= e + 1'b1;
                    end
                end
                COMPUTE: begin
                    acc <= sum;
                    if (k == LAST_IDX) begin
                        k        <= '0;
                        out_data <= sum;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                OUT: if (out_ready) begin
                    acc <= '0;
                    k   <= '0;
                    if (last_elem) begin
                        e <= '0;
                    end else if (j == LAST_IDX) begin
                        j <= '0;
                        i <= i + 1'b1;
                    end else begin
                        j <= j + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mat_mult_seq.sv
// Directed bench for mat_mult_seq: N=2 and N=4 instances share stimulus; the idle one is held in reset.
module tb_mat_mult_seq;
    logic       clk = 1'b0;
    logic       rst2, rst4;
    logic       in_valid, out_ready;
    logic [7:0] in_a, in_b;

    logic        ir2, ov2, ol2, busy2;
    logic [16:0] od2;
    logic        ir4, ov4, ol4, busy4;
    logic [17:0] od4;

    logic        sel4;
    logic        ir, ov, ol, busy;
    logic [31:0] od;

    logic [7:0]  ma [16];
    logic [7:0]  mb [16];
    logic [31:0] expv [16];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mat_mult_seq #(.WIDTH(8), .N(2)) dut2 (
        .clk(clk), .reset(rst2), .in_valid(in_valid), .in_ready(ir2),
        .in_a(in_a), .in_b(in_b), .out_valid(ov2), .out_ready(out_ready),
        .out_data(od2), .out_last(ol2), .busy(busy2));

    mat_mult_seq #(.WIDTH(8), .N(4)) dut4 (
        .clk(clk), .reset(rst4), .in_valid(in_valid), .in_ready(ir4),
        .in_a(in_a), .in_b(in_b), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .out_last(ol4), .busy(busy4));

    always_comb begin
        ir = sel4 ? ir4 : ir2;
        ov = sel4 ? ov4 : ov2;
        ol = sel4 ? ol4 : ol2;
        busy = sel4 ? busy4 : busy2;
        od = sel4 ? 32'(od4) : 32'(od2);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load_beats(input int cnt);
        for (int e = 0; e < cnt; e++) begin
            @(negedge clk);
            chk("load_in_ready", 32'(ir), 1);
            in_valid = 1'b1;
            in_a = ma[e];
            in_b = mb[e];
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!ov && n < 1000) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic collect(input int nn, input bit rnd);
        int  n, guard;
        bit  done;
        for (int idx = 0; idx < nn*nn; idx++) begin
            wait_valid(n);
            if (n >= 1000) begin
                chk("out_timeout", 0, 1);
                return;
            end
            if (idx > 0 && !rnd) chk("gap", 32'(n), 32'(nn));
            chk("data", od, expv[idx]);
            chk("last", 32'(ol), 32'(idx == nn*nn-1));
            chk("in_ready_low", 32'(ir), 0);
            done = 1'b0;
            guard = 0;
            while (!done && guard < 1000) begin
                guard++;
                out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (out_ready) done = 1'b1;
                else begin
                    chk("hold_valid", 32'(ov), 1);
                    chk("hold_data", od, expv[idx]);
                end
            end
            if (!done) chk("accept_timeout", 0, 1);
        end
        out_ready = 1'b0;
        chk("end_in_ready", 32'(ir), 1);
        chk("end_busy", 32'(busy), 0);
        chk("end_valid", 32'(ov), 0);
    endtask

    // Full load, first-result latency, then drain of all results.
    task automatic run(input int nn, input bit rnd);
        int n;
        load_beats(nn*nn);
        wait_valid(n);
        chk("latency", 32'(n), 32'(nn));
        collect(nn, rnd);
    endtask

    task automatic set_2x2_basic();
        ma[0] = 8'd1; ma[1] = 8'd2; ma[2] = 8'd3; ma[3] = 8'd4;
        mb[0] = 8'd5; mb[1] = 8'd6; mb[2] = 8'd7; mb[3] = 8'd8;
        expv[0] = 32'd19; expv[1] = 32'd22; expv[2] = 32'd43; expv[3] = 32'd50;
    endtask

    initial begin
        int n;
        sel4 = 1'b0;
        rst2 = 1'b0;
        rst4 = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_a = '0;
        in_b = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(ir), 1);
        chk("rst_valid", 32'(ov), 0);
        chk("rst_data", od, 0);
        chk("rst_last", 32'(ol), 0);
        chk("rst_busy", 32'(busy), 0);
        rst2 = 1'b1;

        set_2x2_basic();
        run(2, 1'b0);

`ifdef MAT_MULT_SIGNED_EN
        ma[0] = 8'h80; ma[1] = 8'h80; ma[2] = 8'h01; ma[3] = 8'hFF;
        mb[0] = 8'h80; mb[1] = 8'h02; mb[2] = 8'h80; mb[3] = 8'hFD;
        expv[0] = 32'd32768; expv[1] = 32'd128; expv[2] = 32'd0; expv[3] = 32'd5;
`else
        for (int e = 0; e < 4; e++) begin
            ma[e] = 8'd255;
            mb[e] = 8'd255;
            expv[e] = 32'd130050;
        end
`endif
        run(2, 1'b0);

        // Abort a partial load with different data, then a clean load.
        for (int e = 0; e < 4; e++) begin
            ma[e] = 8'd9;
            mb[e] = 8'd9;
        end
        load_beats(3);
        chk("partial_busy", 32'(busy), 1);
        rst2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        set_2x2_basic();
        run(2, 1'b0);

        // Asynchronous reset while a result is stalled.
        load_beats(4);
        wait_valid(n);
        chk("stall_valid", 32'(ov), 1);
        #2 rst2 = 1'b0;
        #1;
        chk("async_valid", 32'(ov), 0);
        chk("async_busy", 32'(busy), 0);
        chk("async_in_ready", 32'(ir), 1);
        @(negedge clk);
        rst2 = 1'b1;

        // N=4: identity A times B = 1..16, random downstream stalls.
        rst2 = 1'b0;
        sel4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b1;
        for (int e = 0; e < 16; e++) begin
            ma[e] = (e / 4 == e % 4) ? 8'd1 : 8'd0;
            mb[e] = 8'(e + 1);
            expv[e] = 32'(e + 1);
        end
        run(4, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
